aurora_rst_seq: RTL
===================

// Module: aurora_rst_seq
// PURPOSE
// - Consumer end of the power-on reset: takes the board/POR active-low reset and runs the Aurora 64B66B
//   bring-up sequence (pma_init, then reset_pb), then waits for channel_up.
// - Supervises the link and re-runs the sequence on link loss, bring-up timeout or software request.
// - Sits between the reset generator and the Aurora core, in the core's init clock domain.
// PARAMETERS
// - P_PMA_CYCLE   128    cycles o_pma_init held high per sequence (>=1, elaboration check)
// - P_PB_CYCLE    64     cycles o_reset_pb held high after o_pma_init drops (>=1)
// - P_TIMEOUT     50000  cycles to wait for channel_up before retry (>=1, < 2**P_CNT_W)
// - P_LOSS_CYCLE  4      consecutive channel_up-low cycles declaring loss (>=1, filter build only)
// - P_CNT_W       16     width of the shared phase counter
// PORTS
// - i_clk         in   1   init/free-running clock
// - i_rst_n       in   1   asynchronous active-low reset
// - i_channel_up  in   1   Aurora channel_up, asynchronous to i_clk
// - i_sw_req      in   1   one-cycle re-init request
// - o_pma_init    out  1   to core pma_init, active high
// - o_reset_pb    out  1   to core reset_pb, active high
// - o_ready       out  1   link up and sequence complete
// - o_retry_cnt   out  8   retries since reset, saturating
// - o_state       out  2   FSM state: 0=PMA 1=PB 2=WAIT 3=RUN
// BEHAVIOUR
// - Reset:
//   - i_rst_n low asynchronously forces state PMA, counter 0, o_pma_init=1, o_reset_pb=1, o_ready=0,
//     o_retry_cnt=0, o_state=0.
//   - Release is synchronised: 2-flop, async assert / sync deassert.
//   - The FSM advances only from the 2nd clock edge after i_rst_n rises.
// - i_channel_up passes through a 2-flop synchroniser (2-cycle latency). "up" below means the synchronised value.
// - PMA:
//   - Outputs pma_init=1, reset_pb=1.
//   - Counter runs 0..P_PMA_CYCLE-1; at terminal count go to PB and clear the counter.
//   - o_pma_init is high for exactly P_PMA_CYCLE cycles.
// - PB:
//   - Outputs pma_init=0, reset_pb=1.
//   - Counter runs 0..P_PB_CYCLE-1, then go to WAIT and clear the counter.
// - WAIT:
//   - Outputs both 0.
//   - up=1: go to RUN.
//   - Counter reaches P_TIMEOUT-1 with up=0: go to PMA and increment retry.
//   - up and timeout in the same cycle: up wins.
// - RUN:
//   - o_ready = up, registered: rises 1 cycle after entry.
//   - Loss of up: go to PMA, increment retry, o_ready=0 on the same edge.
// - i_sw_req:
//   - Any state: go to PMA and clear the counter on the next edge; highest priority.
//   - Increments retry only when issued from RUN or WAIT.
//   - A request during PMA restarts the PMA count.
// - o_retry_cnt saturates at 255. Only i_rst_n clears it.
// - All outputs are registered; no combinational path from input to output.
// CONFIGURATION
// - AURORA_RST_SEQ_LOSS_FILTER_EN defined:
//   - Loss in RUN requires up=0 for P_LOSS_CYCLE consecutive cycles.
//   - Filter counter clears on any up=1.
//   - o_ready drops with the transition, not on the first low cycle.
// - Undefined: a single up=0 cycle in RUN triggers loss. P_LOSS_CYCLE is ignored.
// STRUCTURE
// - Package aurora_rst_pkg: state localparams (S_PMA/S_PB/S_WAIT/S_RUN, 2-bit), RETRY_MAX=8'd255.
// - Sub-module rst_sync_2ff: async-assert/sync-deassert reset synchroniser.
//   - Instantiated once; the channel_up 2-flop stays inline.
// - One counter shared across phases, cleared on every state change.
// TESTING (bench params: PMA=8, PB=4, TIMEOUT=20, LOSS=3)
// - Release i_rst_n, channel_up=0 -> pma_init high 8 cycles, reset_pb high 12 total,
//   WAIT 20 cycles, retry=1, PMA again.
// - channel_up rises 5 cycles into WAIT -> RUN 2 cycles later (sync), o_ready 1 cycle after, retry=0.
// - In RUN:
//   - Filter build: pulse channel_up low 2 cycles -> stays RUN.
//   - Filter build: low 3 cycles -> PMA, retry+1.
//   - No-filter build: 1 low cycle -> PMA.
// - i_sw_req in RUN -> next edge o_pma_init=1, o_ready=0, retry+1.
//   i_sw_req mid-PMA -> PMA count restarts, retry unchanged.
// - Force 260 timeouts -> o_retry_cnt holds 255.
// - Assert i_rst_n low mid-PB -> outputs return to reset values the same cycle (async), sequence restarts on release.

Source files
------------

// File: rtl/aurora_rst_pkg.sv
// Shared definitions for the Aurora 64B66B reset sequencer: FSM state encoding
// and the retry-counter ceiling.
package aurora_rst_pkg;

  typedef enum logic [1:0] {
    S_PMA  = 2'd0,
    S_PB   = 2'd1,
    S_WAIT = 2'd2,
    S_RUN  = 2'd3
  } state_e;

  localparam logic [7:0] RETRY_MAX = 8'd255;

  // Saturating increment so a link that never comes up cannot wrap the count.
  function automatic logic [7:0] retry_inc(input logic [7:0] cnt);
    return (cnt == RETRY_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/aurora_rst_seq_rst_sync_2ff.sv
// Reset synchroniser: asserts asynchronously with i_rst_n and releases two
// i_clk edges after i_rst_n rises.
module rst_sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], 1'b1};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign o_rst_n = sync_q[1];

endmodule

// File: rtl/aurora_rst_seq.sv
// Aurora 64B66B bring-up sequencer: pma_init, then reset_pb, then wait for channel_up;
// re-runs on loss, timeout or software request. Optional loss filter: AURORA_RST_SEQ_LOSS_FILTER_EN.
module aurora_rst_seq
  import aurora_rst_pkg::*;
#(
  parameter int P_PMA_CYCLE  = 128,
  parameter int P_PB_CYCLE   = 64,
  parameter int P_TIMEOUT    = 50000,
  parameter int P_LOSS_CYCLE = 4,
  parameter int P_CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_channel_up,
  input  logic       i_sw_req,
  output logic       o_pma_init,
  output logic       o_reset_pb,
  output logic       o_ready,
  output logic [7:0] o_retry_cnt,
  output logic [1:0] o_state
);

  if (P_PMA_CYCLE < 1) begin : g_chk_pma
    $error("aurora_rst_seq: P_PMA_CYCLE must be >= 1");
  end
  if (P_PB_CYCLE < 1) begin : g_chk_pb
    $error("aurora_rst_seq: P_PB_CYCLE must be >= 1");
  end
  if ((P_TIMEOUT < 1) || (P_TIMEOUT >= (1 << P_CNT_W))) begin : g_chk_timeout
    $error("aurora_rst_seq: P_TIMEOUT must be >= 1 and fit in P_CNT_W bits");
  end
  if (P_LOSS_CYCLE < 1) begin : g_chk_loss
    $error("aurora_rst_seq: P_LOSS_CYCLE must be >= 1");
  end

  localparam logic [P_CNT_W-1:0] CNT_ONE   = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] PMA_LAST  = P_CNT_W'(P_PMA_CYCLE - 1);
  localparam logic [P_CNT_W-1:0] PB_LAST   = P_CNT_W'(P_PB_CYCLE - 1);
  localparam logic [P_CNT_W-1:0] WAIT_LAST = P_CNT_W'(P_TIMEOUT - 1);
`ifdef AURORA_RST_SEQ_LOSS_FILTER_EN
  localparam logic [P_CNT_W-1:0] LOSS_LAST = P_CNT_W'(P_LOSS_CYCLE - 1);
`endif

  logic               rst_n_sync;
  logic [1:0]         up_sync_q;
  logic [1:0]         up_sync_d;
  logic               up;

  state_e             state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         retry_q, retry_d;
  logic               pma_init_q, pma_init_d;
  logic               reset_pb_q, reset_pb_d;
  logic               ready_q, ready_d;
  logic               bump;

  rst_sync_2ff u_rst_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_rst_n (rst_n_sync)
  );

  assign up = up_sync_q[1];

  always_comb begin
    up_sync_d  = {up_sync_q[0], i_channel_up};
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    bump       = 1'b0;

    // A software request overrides every phase and restarts the count.
    if (i_sw_req) begin
      state_d = S_PMA;
      cnt_d   = '0;
      bump    = (state_q == S_RUN) || (state_q == S_WAIT);
    end else begin
      unique case (state_q)
        S_PMA: begin
          if (cnt_q == PMA_LAST) begin
            state_d = S_PB;
            cnt_d   = '0;
          end
        end
        S_PB: begin
          if (cnt_q == PB_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
        S_WAIT: begin
          if (up) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_PMA;
            cnt_d   = '0;
            bump    = 1'b1;
          end
        end
        S_RUN: begin
`ifdef AURORA_RST_SEQ_LOSS_FILTER_EN
          // In RUN the shared counter tracks consecutive low samples of up.
          if (up) begin
            cnt_d = '0;
          end else if (cnt_q == LOSS_LAST) begin
            state_d = S_PMA;
            cnt_d   = '0;
            bump    = 1'b1;
          end
`else
          cnt_d = '0;
          if (!up) begin
            state_d = S_PMA;
            bump    = 1'b1;
          end
`endif
        end
        default: begin
          state_d = S_PMA;
          cnt_d   = '0;
        end
      endcase
    end

    retry_d    = bump ? retry_inc(retry_q) : retry_q;
    pma_init_d = (state_d == S_PMA);
    reset_pb_d = (state_d == S_PMA) || (state_d == S_PB);
    // Ready holds through filtered low samples and drops only on leaving RUN.
    ready_d    = (state_q == S_RUN) && (state_d == S_RUN) && (up || ready_q);
  end

  always_ff @(posedge i_clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      up_sync_q  <= 2'b00;
      state_q    <= S_PMA;
      cnt_q      <= '0;
      retry_q    <= 8'd0;
      pma_init_q <= 1'b1;
      reset_pb_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      up_sync_q  <= up_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      pma_init_q <= pma_init_d;
      reset_pb_q <= reset_pb_d;
      ready_q    <= ready_d;
    end
  end

  assign o_pma_init  = pma_init_q;
  assign o_reset_pb  = reset_pb_q;
  assign o_ready     = ready_q;
  assign o_retry_cnt = retry_q;
  assign o_state     = state_q;

endmodule
